// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and sizing helpers for the serial sequence-detect controller.
package seq_detect_ctrl_pkg;

    localparam int MAX_LEN_DEFAULT = 8;
    localparam int CNT_W_DEFAULT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_shifter.sv
// History shift register with saturating fill counter and length-masked compare.
// hit reflects the post-shift history and is only raised on a shift cycle.
module seq_match_shifter
    import seq_detect_ctrl_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = (hist_q << 1) | MAX_LEN'(bit_in);
            if (fill_q != LEN_W'(MAX_LEN))
                fill_d = fill_q + 1'b1;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
    end

    // Only bits below len take part; fill guards against matching stale zeros.
    always_comb begin
        hit = shift_en && !clear && (fill_d >= len) &&
              (((hist_d ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/sequence_detect_controller.sv
// Programmable serial pattern detector with a counted scan session.
// Define SEQ_DETECT_CTRL_TIMEOUT_EN to add the idle-input timeout.
module sequence_detect_controller
    import seq_detect_ctrl_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         bit_valid,
    input  logic                         bit_in,
    output logic                         bit_ready,
    output logic                         detected,
    output logic [CNT_W-1:0]             match_count,
    output logic                         busy,
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    input  logic [15:0]                  timeout_cycles,
    output logic                         timed_out,
`endif
    output logic                         done
);

    localparam int LEN_W = len_width(MAX_LEN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic               loaded_q, loaded_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               detected_q, detected_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_ready_q, bit_ready_d;

    logic               cfg_hs, bit_hs, shift_en, clear_hist, hit;
    logic [CNT_W-1:0]   count_inc;

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    logic [15:0]        idle_cnt_q, idle_cnt_d;
    logic               timed_out_q, timed_out_d;
`endif

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign bit_hs    = bit_valid && bit_ready_q;
    // A bit taken in the abort cycle is swallowed without being evaluated.
    assign shift_en  = bit_hs && !abort;
    assign count_inc = count_q + 1'b1;

    seq_match_shifter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (clear_hist),
        .bit_in   (bit_in),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        target_d    = target_q;
        loaded_d    = loaded_q;
        count_d     = count_q;
        detected_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        bit_ready_d = bit_ready_q;
        clear_hist  = 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        idle_cnt_d  = '0;
        timed_out_d = 1'b0;
`endif

        if (cfg_hs) begin
            pat_d    = cfg_pattern;
            target_d = cfg_target;
            loaded_d = 1'b1;
            if (cfg_len == '0)
                len_d = LEN_W'(1);
            else if (cfg_len > LEN_W'(MAX_LEN))
                len_d = LEN_W'(MAX_LEN);
            else
                len_d = cfg_len;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A config write wins over a start in the same cycle.
                if (start && !cfg_hs && loaded_q) begin
                    state_d    = ST_ARMED;
                    clear_hist = 1'b1;
                    count_d    = '0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    state_d     = ST_RUN;
                    bit_ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b0;
                    bit_ready_d = 1'b0;
                end else if (hit) begin
                    detected_d = 1'b1;
                    if (count_q != {CNT_W{1'b1}})
                        count_d = count_inc;
                    if (target_q != '0 && count_inc == target_q) begin
                        state_d     = ST_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        bit_ready_d = 1'b0;
                    end
                end
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                if (!abort && !bit_hs) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    if (timeout_cycles != '0 && idle_cnt_d == timeout_cycles) begin
                        state_d     = ST_IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b0;
                        bit_ready_d = 1'b0;
                        timed_out_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= LEN_W'(1);
            target_q    <= '0;
            loaded_q    <= 1'b0;
            count_q     <= '0;
            detected_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bit_ready_q <= 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            idle_cnt_q  <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            target_q    <= target_d;
            loaded_q    <= loaded_d;
            count_q     <= count_d;
            detected_q  <= detected_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bit_ready_q <= bit_ready_d;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    assign bit_ready   = bit_ready_q;
    assign detected    = detected_q;
    assign match_count = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    assign timed_out   = timed_out_q;
`endif

endmodule

// File: tb/tb_sequence_detect_controller.sv
// Scoreboard bench for sequence_detect_controller: a bit-level model pushes
// expected match counts per consumed bit, a monitor pops them on each pulse.
module tb_sequence_detect_controller;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [7:0]       cfg_pattern = '0;
    logic [3:0]       cfg_len = '0;
    logic [7:0]       cfg_target = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_ready;
    logic             detected;
    logic [7:0]       match_count;
    logic             busy;
    logic             done;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    logic [15:0]      timeout_cycles = '0;
    logic             timed_out;
`endif

    int errors = 0;
    int checks = 0;

    int         exp_q[$];
    logic [7:0] m_hist, m_pat, m_mask;
    int         m_fill, m_len, m_count;
    logic       hs_prev = 1'b0;

    sequence_detect_controller #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_pattern    (cfg_pattern),
        .cfg_len        (cfg_len),
        .cfg_target     (cfg_target),
        .start          (start),
        .abort          (abort),
        .bit_valid      (bit_valid),
        .bit_in         (bit_in),
        .bit_ready      (bit_ready),
        .detected       (detected),
        .match_count    (match_count),
        .busy           (busy),
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        .timeout_cycles (timeout_cycles),
        .timed_out      (timed_out),
`endif
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) hs_prev <= bit_valid && bit_ready;

    // Every pulse must follow a handshake and match the next expected count.
    always @(negedge clk) begin
        if (!rst && detected) begin
            checks++;
            if (!hs_prev) begin
                errors++;
                $display("FAIL det_no_handshake: detected=1 without prior handshake at %0t", $time);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL det_unexpected: got pulse count=%0d, expected no pulse at %0t", match_count, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (match_count !== e[7:0]) begin
                    errors++;
                    $display("FAIL det_count: got %0d, expected %0d at %0t", match_count, e, $time);
                end
            end
        end
    end

    task automatic model_bit(input logic b);
        m_hist = {m_hist[6:0], b};
        if (m_fill < MAX_LEN) m_fill++;
        if (m_fill >= m_len && ((m_hist ^ m_pat) & m_mask) == 8'h00) begin
            if (m_count < 255) m_count++;
            exp_q.push_back(m_count);
        end
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len_raw,
                            input logic [7:0] tgt, input int eff_len, input bit with_start);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len_raw; cfg_target = tgt;
        start = with_start;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0;
        m_pat = pat; m_len = eff_len;
        for (int i = 0; i < 8; i++) m_mask[i] = (i < eff_len);
    endtask

    task automatic start_session();
        @(negedge clk);
        start = 1'b1;
        m_hist = '0; m_fill = 0; m_count = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go_idle();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // bits[n-1] is the first bit to arrive.
    task automatic feed(input logic [63:0] bits, input int n, input bit gap,
                        input int budget, output int consumed);
        int  i;
        int  cyc;
        bit  on;
        i = 0; cyc = 0; on = 1'b0; consumed = 0;
        while (i < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            on = gap ? ~on : 1'b1;
            bit_valid = on;
            bit_in = bits[n-1-i];
            if (on && bit_ready) begin
                model_bit(bits[n-1-i]);
                i++;
                consumed++;
            end
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (bit_ready) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_run: bit_ready=0, expected 1 within 10 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (detected !== 1'b0)    begin errors++; $display("FAIL rst_detected: got %b, expected 0", detected); end
        if (match_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d, expected 0", match_count); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("FAIL rst_done: got %b, expected 0", done); end
        if (bit_ready !== 1'b0)   begin errors++; $display("FAIL rst_bit_ready: got %b, expected 0", bit_ready); end
        if (cfg_ready !== 1'b1)   begin errors++; $display("FAIL rst_cfg_ready: got %b, expected 1", cfg_ready); end
        rst = 1'b0;
    endtask

    task automatic test_start_rules();
        start_session();
        repeat (2) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)      begin errors++; $display("FAIL nocfg_busy: got %b, expected 0", busy); end
        if (bit_ready !== 1'b0) begin errors++; $display("FAIL nocfg_bit_ready: got %b, expected 0", bit_ready); end
        load_cfg(8'b0000_1010, 4'd4, 8'd1, 4, 1'b1);
        repeat (2) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)      begin errors++; $display("FAIL cfgstart_busy: got %b, expected 0", busy); end
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfgstart_cfg_ready: got %b, expected 1", cfg_ready); end
    endtask

    task automatic test_target();
        int c;
        start_session();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL tgt_busy_armed: got %b, expected 1", busy); end
        feed(64'b101010, 6, 1'b0, 20, c);
        checks += 5;
        if (c != 4)                begin errors++; $display("FAIL tgt_consumed: got %0d, expected 4", c); end
        if (done !== 1'b1)         begin errors++; $display("FAIL tgt_done: got %b, expected 1", done); end
        if (bit_ready !== 1'b0)    begin errors++; $display("FAIL tgt_bit_ready: got %b, expected 0", bit_ready); end
        if (match_count !== 8'd1)  begin errors++; $display("FAIL tgt_count: got %0d, expected 1", match_count); end
        if (cfg_ready !== 1'b1)    begin errors++; $display("FAIL tgt_cfg_ready: got %b, expected 1", cfg_ready); end
    endtask

    task automatic test_overlap();
        int c;
        load_cfg(8'b0011_0011, 4'd6, 8'd0, 6, 1'b0);
        start_session();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL ovl_done_cleared: got %b, expected 0", done); end
        feed(64'b1100110011, 10, 1'b0, 30, c);
        checks += 2;
        if (match_count !== 8'd2) begin errors++; $display("FAIL ovl_count: got %0d, expected 2", match_count); end
        if (busy !== 1'b1)        begin errors++; $display("FAIL ovl_busy: got %b, expected 1", busy); end
        go_idle();
    endtask

    task automatic test_abort();
        int c;
        bit ok;
        load_cfg(8'b0000_1010, 4'd4, 8'd0, 4, 1'b0);
        start_session();
        feed(64'b101, 3, 1'b0, 20, c);
        // The closing 0 would complete the pattern but rides the abort cycle.
        @(negedge clk);
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
        @(negedge clk);
        abort = 1'b0; bit_valid = 1'b0;
        checks += 4;
        if (detected !== 1'b0)  begin errors++; $display("FAIL abort_detected: got %b, expected 0", detected); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL abort_done: got %b, expected 0", done); end
        if (bit_ready !== 1'b0) begin errors++; $display("FAIL abort_bit_ready: got %b, expected 0", bit_ready); end
        start_session();
        wait_run(ok);
        feed(64'b1010, 4, 1'b0, 20, c);
        checks++;
        if (match_count !== 8'd1) begin errors++; $display("FAIL abort_restart_count: got %0d, expected 1", match_count); end
        go_idle();
    endtask

    task automatic test_gapped();
        int c;
        load_cfg(8'b0000_0011, 4'd2, 8'd0, 2, 1'b0);
        start_session();
        feed(64'b111, 3, 1'b1, 30, c);
        checks++;
        if (match_count !== 8'd2) begin errors++; $display("FAIL gap_count: got %0d, expected 2", match_count); end
        go_idle();
    endtask

    task automatic test_len_clamp();
        int c;
        load_cfg(8'b0000_0001, 4'd0, 8'd0, 1, 1'b0);
        start_session();
        feed(64'b101, 3, 1'b0, 20, c);
        checks++;
        if (match_count !== 8'd2) begin errors++; $display("FAIL clamp0_count: got %0d, expected 2", match_count); end
        go_idle();
        load_cfg(8'hA5, 4'd15, 8'd0, 8, 1'b0);
        start_session();
        feed(64'b1010_0101, 8, 1'b0, 20, c);
        checks++;
        if (match_count !== 8'd1) begin errors++; $display("FAIL clamp15_count: got %0d, expected 1", match_count); end
        go_idle();
    endtask

    task automatic test_saturate();
        int c;
        load_cfg(8'b0000_0001, 4'd1, 8'd0, 1, 1'b0);
        start_session();
        for (int r = 0; r < 5; r++) feed({64{1'b1}}, 64, 1'b0, 140, c);
        checks += 2;
        if (match_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d, expected 255", match_count); end
        if (busy !== 1'b1)          begin errors++; $display("FAIL sat_busy: got %b, expected 1", busy); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        int c;
        load_cfg(8'b0000_0011, 4'd2, 8'd0, 2, 1'b0);
        start_session();
        feed(64'b11, 2, 1'b0, 20, c);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (busy !== 1'b0)        begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        if (match_count !== 8'd0) begin errors++; $display("FAIL rstmid_count: got %0d, expected 0", match_count); end
        if (bit_ready !== 1'b0)   begin errors++; $display("FAIL rstmid_bit_ready: got %b, expected 0", bit_ready); end
        start_session();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_cfg_cleared: busy=%b, expected 0", busy); end
    endtask

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int first;
        int pulses;
        load_cfg(8'b0000_1010, 4'd4, 8'd0, 4, 1'b0);
        timeout_cycles = 16'd5;
        start_session();
        wait_run(ok);
        first = 0; pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (timed_out === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        checks += 3;
        if (first != 5)    begin errors++; $display("FAIL to_cycle: pulse at %0d, expected 5", first); end
        if (pulses != 1)   begin errors++; $display("FAIL to_pulses: got %0d, expected 1", pulses); end
        if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b, expected 0", busy); end
        start_session();
        wait_run(ok);
        repeat (3) @(negedge clk);
        @(negedge clk);
        bit_valid = 1'b1; bit_in = 1'b0;
        if (bit_ready) model_bit(1'b0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bit_valid = 1'b0;
            if (timed_out === 1'b1) pulses++;
        end
        checks += 2;
        if (pulses != 0)   begin errors++; $display("FAIL to_restart_pulses: got %0d, expected 0", pulses); end
        if (busy !== 1'b1) begin errors++; $display("FAIL to_restart_busy: got %b, expected 1", busy); end
        go_idle();
        timeout_cycles = 16'd0;
    endtask
`endif

    initial begin
        m_hist = '0; m_pat = '0; m_mask = '0; m_fill = 0; m_len = 1; m_count = 0;
        test_reset();
        test_start_rules();
        test_target();
        test_overlap();
        test_abort();
        test_gapped();
        test_len_clamp();
        test_saturate();
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected pulses never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequence_detect_controller.md
Name: sequence_detect_controller

Overview:
- Runtime-programmable serial pattern detector controller with a counted scan session.
- Software loads a pattern of 1..MAX_LEN bits and a match target, then starts a scan.
- The block accepts a gated serial bit stream and pulses on every overlapping match.
- It stops after the target count or on abort; it sits between the config interface and the serial-bit source.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits.
- CNT_W, 8, width of the match counter and the target.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready.
- cfg_pattern  in  MAX_LEN  pattern; bit 0 = most recent bit.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN.
- cfg_target  in  CNT_W  matches to finish a session; 0 = unlimited.
- start  in  1  single-cycle session start.
- abort  in  1  single-cycle session abort.
- bit_valid  in  1  serial bit present.
- bit_in  in  1  serial bit.
- bit_ready  out  1  bit consumed when bit_valid && bit_ready.
- detected  out  1  one-cycle match pulse.
- match_count  out  CNT_W  matches in the current session.
- busy  out  1  session running.
- done  out  1  session finished by reaching the target.

Behaviour:
- States: IDLE, ARMED, RUN, DONE.
- Reset values:
  - State is IDLE.
  - detected=0, match_count=0, busy=0, done=0, bit_ready=0.
  - Config-loaded flag is 0.
- cfg_ready is 1 in IDLE and DONE, 0 otherwise.
- Config acceptance:
  - On an accepted config, latch pattern, len and target, and set the loaded flag.
  - cfg_len is clamped: 0 becomes 1, values >MAX_LEN become MAX_LEN.
- IDLE or DONE, on start:
  - If the loaded flag is set, go to ARMED.
  - In the same cycle, clear the history, the valid-bit counter, match_count and done.
  - start with no config loaded is ignored.
- Same-cycle cfg handshake and start: the config is accepted and start is ignored.
- ARMED lasts exactly one cycle, then RUN. bit_ready=0 in ARMED.
- RUN:
  - bit_ready=1 and busy=1.
  - On a handshake, shift bit_in into history bit 0.
  - The fill counter saturates at MAX_LEN.
- Match condition: fill ≥ len and history[len-1:0] == pattern[len-1:0].
  - The condition is evaluated on the post-shift value.
  - detected pulses in the cycle after the accepting handshake.
  - match_count increments in that same cycle.
  - Overlapping matches are counted; history is not cleared on a match.
- Target reached (target≠0 and the match makes match_count equal target):
  - Next state is DONE, and done=1 is held.
  - bit_ready drops in the same cycle detected rises, so no further bit is consumed.
  - match_count holds in DONE.
- Unlimited target: match_count saturates at all-ones; detected still pulses.
- abort in ARMED or RUN:
  - Next state is IDLE, busy=0, done=0, and no detected pulse.
  - A handshake in the abort cycle is consumed but not evaluated.
- match_count holds its value after abort.
- rst mid-session returns to reset values and clears the config.

Optional Feature:
- Macro: SEQ_DETECT_CTRL_TIMEOUT_EN.
- When defined:
  - Adds input timeout_cycles[15:0] and output timed_out.
  - In RUN, count consecutive cycles without bit_valid; any handshake restarts the count.
  - When the count reaches timeout_cycles (0 disables), go to IDLE and pulse timed_out for 1 cycle.
- When undefined: no such ports and no counter.

Decomposition:
- Package seq_detect_ctrl_pkg holds:
  - The state enum type.
  - Localparams MAX_LEN_DEFAULT and CNT_W_DEFAULT.
  - The length-width function.
- Sub-module seq_match_shifter holds the history shift register, fill counter and masked comparator.
  - Inputs: shift_en, clear, bit_in, pattern, len.
  - Output: hit, combinational on the post-shift value.
- The controller FSM and counters stay in the top module.

Test Plan:
- Pattern 6'b110011, len 6, target 0; stream 1,1,0,0,1,1,0,0,1,1 in arrival order → detected after bits 6 and 10; match_count=2.
- Pattern 4'b1010, len 4, target 1; stream 1,0,1,0,1,0 → one pulse after bit 4, done=1, bit_ready=0; bits 5-6 not consumed.
- start with no config → stays IDLE, busy=0. Config plus start in the same cycle → config loaded, still IDLE.
- Abort in RUN after 3 bits of 1010 → IDLE, no pulse. Restart, then stream 1010 → pulse with match_count=1.
- bit_valid toggling every other cycle with pattern 11, len 2 → detections occur only on handshake cycles. Stream 1,1,1 → 2 matches.
- With SEQ_DETECT_CTRL_TIMEOUT_EN and timeout_cycles=5 → 5 idle RUN cycles give a timed_out pulse and IDLE; 4 idle cycles then a bit → no timeout.
